lsu_mem_port: RTL

- Load/store unit that consumes the ALU's address output (`alu_result`) for the memory alucodes (`ALU_LB`..`ALU_SW` from define.vh).
- Performs the data-memory access over a req/ack bus and returns aligned, sign/zero-extended load data to writeback.
- Sits between execute and the data memory. It is the consumer end of the ALU's memory-operation results.

---
 rtl/lsu_mem_port.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit between execute and the data memory.
// Takes the ALU result as an effective address for memory alucodes, runs one
// req/ack bus cycle, and returns aligned, sign/zero-extended load data.
// Non-memory alucodes pass addr straight through as the response.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake from execute (ready only in IDLE)
//   alucode, addr     operation code and effective address / pass-through
//   store_data        rs2 value for stores
//   resp_*            one-cycle response pulse with data and error flags
//   mem_*             data-memory bus (request held until mem_ack)
module lsu_mem_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  alucode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_misalign,
    output logic        resp_bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Memory alucodes, same encoding as define.vh.
    localparam logic [5:0] ALU_LB  = 6'd9;
    localparam logic [5:0] ALU_LH  = 6'd10;
    localparam logic [5:0] ALU_LW  = 6'd11;
    localparam logic [5:0] ALU_LBU = 6'd12;
    localparam logic [5:0] ALU_LHU = 6'd13;
    localparam logic [5:0] ALU_SB  = 6'd14;
    localparam logic [5:0] ALU_SH  = 6'd15;
    localparam logic [5:0] ALU_SW  = 6'd16;

    typedef enum logic [1:0] {IDLE, MEM_WAIT, RESP} state_t;

    state_t      state_reg, state_next;
    logic        req_ready_reg, req_ready_next;
    logic        resp_valid_reg, resp_valid_next;
    logic [31:0] resp_data_reg, resp_data_next;
    logic        resp_misalign_reg, resp_misalign_next;
    logic        resp_bus_err_reg, resp_bus_err_next;
    logic        mem_req_reg, mem_req_next;
    logic        mem_we_reg, mem_we_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [3:0]  mem_wstrb_reg, mem_wstrb_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [5:0]  op_reg, op_next;
    logic [1:0]  off_reg, off_next;

    // Request decode
    logic is_load, is_store, is_mem, misalign, accept;
    logic [3:0]  sb_wstrb, sh_wstrb, st_wstrb;
    logic [31:0] sb_wdata, sh_wdata, st_wdata;

    assign is_load  = (alucode >= ALU_LB) && (alucode <= ALU_LHU);
    assign is_store = (alucode >= ALU_SB) && (alucode <= ALU_SW);
    assign is_mem   = is_load || is_store;
    assign accept   = req_valid && req_ready_reg;

    always_comb begin
        misalign = 1'b0;
        case (alucode)
            ALU_LH, ALU_LHU, ALU_SH: misalign = addr[0];
            ALU_LW, ALU_SW:          misalign = (addr[1:0] != 2'b00);
            default:                 misalign = 1'b0;
        endcase
    end

    // Per-lane store strobes and replicated data.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign sb_wstrb[gi]        = (addr[1:0] == 2'(gi));
            assign sh_wstrb[gi]        = (addr[1] == 1'(gi / 2));
            assign sb_wdata[gi*8 +: 8] = store_data[7:0];
            assign sh_wdata[gi*8 +: 8] = store_data[(gi % 2)*8 +: 8];
        end
    endgenerate

    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = store_data;
        if (alucode == ALU_SB) begin
            st_wstrb = sb_wstrb;
            st_wdata = sb_wdata;
        end else if (alucode == ALU_SH) begin
            st_wstrb = sh_wstrb;
            st_wdata = sh_wdata;
        end
    end

    // Load extraction from the acked word, using the latched op and offset.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_result;

    assign ld_byte = mem_rdata[{off_reg, 3'b000} +: 8];
    assign ld_half = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (op_reg)
            ALU_LB:  ld_result = {{24{ld_byte[7]}}, ld_byte};
            ALU_LBU: ld_result = {24'd0, ld_byte};
            ALU_LH:  ld_result = {{16{ld_half[15]}}, ld_half};
            ALU_LHU: ld_result = {16'd0, ld_half};
            ALU_LW:  ld_result = mem_rdata;
            default: ld_result = 32'd0;   // stores respond with 0
        endcase
    end

    // Timeout fires on the cycle the incremented count reaches the limit,
    // so mem_req stays high for exactly TIMEOUT_CYCLES cycles.
    logic [31:0] cnt_inc;
    logic        timeout_hit;
    assign cnt_inc     = cnt_reg + 32'd1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_CYCLES);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            req_ready_reg     <= 1'b1;
            resp_valid_reg    <= 1'b0;
            resp_data_reg     <= 32'd0;
            resp_misalign_reg <= 1'b0;
            resp_bus_err_reg  <= 1'b0;
            mem_req_reg       <= 1'b0;
            mem_we_reg        <= 1'b0;
            mem_addr_reg      <= 32'd0;
            mem_wstrb_reg     <= 4'd0;
            mem_wdata_reg     <= 32'd0;
            cnt_reg           <= 32'd0;
            op_reg            <= 6'd0;
            off_reg           <= 2'd0;
        end else begin
            state_reg         <= state_next;
            req_ready_reg     <= req_ready_next;
            resp_valid_reg    <= resp_valid_next;
            resp_data_reg     <= resp_data_next;
            resp_misalign_reg <= resp_misalign_next;
            resp_bus_err_reg  <= resp_bus_err_next;
            mem_req_reg       <= mem_req_next;
            mem_we_reg        <= mem_we_next;
            mem_addr_reg      <= mem_addr_next;
            mem_wstrb_reg     <= mem_wstrb_next;
            mem_wdata_reg     <= mem_wdata_next;
            cnt_reg           <= cnt_next;
            op_reg            <= op_next;
            off_reg           <= off_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept)
                    state_next = (is_mem && !misalign) ? MEM_WAIT : RESP;
            end
            MEM_WAIT: begin
                if (mem_ack || timeout_hit)
                    state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered-output next values
    always_comb begin
        req_ready_next     = (state_next == IDLE);
        resp_valid_next    = 1'b0;
        resp_data_next     = 32'd0;
        resp_misalign_next = 1'b0;
        resp_bus_err_next  = 1'b0;
        mem_req_next       = mem_req_reg;
        mem_we_next        = mem_we_reg;
        mem_addr_next      = mem_addr_reg;
        mem_wstrb_next     = mem_wstrb_reg;
        mem_wdata_next     = mem_wdata_reg;
        cnt_next           = cnt_reg;
        op_next            = op_reg;
        off_next           = off_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    op_next  = alucode;
                    off_next = addr[1:0];
                    cnt_next = 32'd0;
                    if (is_mem && !misalign) begin
                        mem_req_next   = 1'b1;
                        mem_we_next    = is_store;
                        mem_addr_next  = {addr[31:2], 2'b00};
                        mem_wstrb_next = is_store ? st_wstrb : 4'd0;
                        mem_wdata_next = is_store ? st_wdata : 32'd0;
                    end else if (is_mem) begin
                        resp_valid_next    = 1'b1;
                        resp_misalign_next = 1'b1;
                    end else begin
                        resp_valid_next = 1'b1;
                        resp_data_next  = addr;
                    end
                end
            end
            MEM_WAIT: begin
                cnt_next = cnt_inc;
                if (mem_ack || timeout_hit) begin
                    mem_req_next      = 1'b0;
                    mem_we_next       = 1'b0;
                    mem_addr_next     = 32'd0;
                    mem_wstrb_next    = 4'd0;
                    mem_wdata_next    = 32'd0;
                    resp_valid_next   = 1'b1;
                    // ack takes priority over a simultaneous timeout
                    resp_data_next    = mem_ack ? ld_result : 32'd0;
                    resp_bus_err_next = !mem_ack;
                end
            end
            default: ;
        endcase
    end

    assign req_ready     = req_ready_reg;
    assign resp_valid    = resp_valid_reg;
    assign resp_data     = resp_data_reg;
    assign resp_misalign = resp_misalign_reg;
    assign resp_bus_err  = resp_bus_err_reg;
    assign mem_req       = mem_req_reg;
    assign mem_we        = mem_we_reg;
    assign mem_addr      = mem_addr_reg;
    assign mem_wstrb     = mem_wstrb_reg;
    assign mem_wdata     = mem_wdata_reg;

endmodule
